// File: rtl/dma_seg_ram_sdp_pkg.sv
// rtl/dma_seg_ram_sdp_pkg.sv - shared sizing helpers for the segmented DMA buffer RAM
package dma_seg_ram_sdp_pkg;

  // Word-address width of one segment bank for a given total byte size.
  function automatic int seg_addr_width(input int size, input int seg_count, input int seg_be_width);
    return $clog2(size / (seg_count * seg_be_width));
  endfunction

endpackage

// File: rtl/dma_seg_ram_sdp_if.sv
// rtl/dma_seg_ram_sdp_if.sv - segment write/read command and response channels
interface dma_seg_ram_sdp_if
  import dma_seg_ram_sdp_pkg::*;
#(
  parameter int SIZE           = 16384,
  parameter int SEG_COUNT      = 2,
  parameter int SEG_DATA_WIDTH = 64,
  parameter int SEG_BE_WIDTH   = SEG_DATA_WIDTH / 8,
  parameter int SEG_ADDR_WIDTH = seg_addr_width(SIZE, SEG_COUNT, SEG_BE_WIDTH)
);
  logic [SEG_COUNT*SEG_BE_WIDTH-1:0]   wr_cmd_be;
  logic [SEG_COUNT*SEG_ADDR_WIDTH-1:0] wr_cmd_addr;
  logic [SEG_COUNT*SEG_DATA_WIDTH-1:0] wr_cmd_data;
  logic [SEG_COUNT-1:0]                wr_cmd_valid;
  logic [SEG_COUNT-1:0]                wr_cmd_ready;
  logic [SEG_COUNT-1:0]                wr_done;
  logic [SEG_COUNT*SEG_ADDR_WIDTH-1:0] rd_cmd_addr;
  logic [SEG_COUNT-1:0]                rd_cmd_valid;
  logic [SEG_COUNT-1:0]                rd_cmd_ready;
  logic [SEG_COUNT*SEG_DATA_WIDTH-1:0] rd_resp_data;
  logic [SEG_COUNT-1:0]                rd_resp_valid;
  logic [SEG_COUNT-1:0]                rd_resp_ready;

  modport master (
    output wr_cmd_be, wr_cmd_addr, wr_cmd_data, wr_cmd_valid,
    output rd_cmd_addr, rd_cmd_valid, rd_resp_ready,
    input  wr_cmd_ready, wr_done, rd_cmd_ready, rd_resp_data, rd_resp_valid
  );

  modport slave (
    input  wr_cmd_be, wr_cmd_addr, wr_cmd_data, wr_cmd_valid,
    input  rd_cmd_addr, rd_cmd_valid, rd_resp_ready,
    output wr_cmd_ready, wr_done, rd_cmd_ready, rd_resp_data, rd_resp_valid
  );
endinterface

// File: rtl/dma_seg_ram_rd_pipe.sv
// rtl/dma_seg_ram_rd_pipe.sv - one segment's read valid chain, data registers and ready logic
module dma_seg_ram_rd_pipe #(
  parameter int PIPELINE       = 2,
  parameter int SEG_DATA_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  output logic                      ram_rd_en,
  input  logic [SEG_DATA_WIDTH-1:0] ram_rd_data,
  output logic [SEG_DATA_WIDTH-1:0] resp_data,
  output logic                      resp_valid,
  input  logic                      resp_ready
);
  logic [PIPELINE-1:0] valid_q;
  logic [PIPELINE-1:0] adv;

  // A stage may move on when the stage after it is empty or itself moving.
  always_comb begin : p_adv
    logic go;
    go = resp_ready;
    adv = '0;
    adv[PIPELINE-1] = go;
    for (int k = PIPELINE - 2; k >= 0; k--) begin
      go = !valid_q[k+1] || go;
      adv[k] = go;
    end
  end

  assign cmd_ready  = !rst && (!valid_q[0] || adv[0]);
  assign ram_rd_en  = cmd_valid && cmd_ready;
  assign resp_valid = valid_q[PIPELINE-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      if (cmd_ready) valid_q[0] <= cmd_valid;
      for (int k = 1; k < PIPELINE; k++) begin
        if (adv[k-1]) valid_q[k] <= valid_q[k-1];
      end
    end
  end

  generate
    if (PIPELINE == 1) begin : g_direct
      assign resp_data = ram_rd_data;
    end else begin : g_regs
      // data_q[j] holds stage j+1; stage 0 data is the RAM output register.
      logic [SEG_DATA_WIDTH-1:0] data_q [PIPELINE-1];

      always_ff @(posedge clk) begin
        if (!rst) begin
          if (adv[0] && valid_q[0]) data_q[0] <= ram_rd_data;
          for (int j = 1; j < PIPELINE - 1; j++) begin
            if (adv[j] && valid_q[j]) data_q[j] <= data_q[j-1];
          end
        end
      end

      assign resp_data = data_q[PIPELINE-2];
    end
  endgenerate
endmodule

// File: rtl/dma_seg_ram_sdp.sv
// rtl/dma_seg_ram_sdp.sv - segmented simple-dual-port DMA buffer RAM with pipelined reads
module dma_seg_ram_sdp
  import dma_seg_ram_sdp_pkg::*;
#(
  parameter int SIZE           = 16384,
  parameter int SEG_COUNT      = 2,
  parameter int SEG_DATA_WIDTH = 64,
  parameter int SEG_BE_WIDTH   = SEG_DATA_WIDTH / 8,
  parameter int SEG_ADDR_WIDTH = seg_addr_width(SIZE, SEG_COUNT, SEG_BE_WIDTH),
  parameter int PIPELINE       = 2
) (
  input  logic              clk,
  input  logic              rst,
  dma_seg_ram_sdp_if.slave  bus
);
  localparam int SEG_DEPTH = SIZE / (SEG_COUNT * SEG_BE_WIDTH);
  localparam int BYTE_W    = SEG_DATA_WIDTH / SEG_BE_WIDTH;

  logic [SEG_COUNT-1:0]                wr_en;
  logic [SEG_COUNT-1:0]                wr_done_q;
  logic [SEG_COUNT-1:0]                rd_en;
  logic [SEG_COUNT-1:0]                rd_cmd_ready;
  logic [SEG_COUNT-1:0]                rd_resp_valid;
  logic [SEG_COUNT*SEG_DATA_WIDTH-1:0] rd_resp_data;

  assign wr_en = bus.wr_cmd_valid & {SEG_COUNT{~rst}};

  always_ff @(posedge clk) begin
    if (rst) wr_done_q <= '0;
    else     wr_done_q <= wr_en;
  end

  assign bus.wr_cmd_ready  = {SEG_COUNT{~rst}};
  assign bus.wr_done       = wr_done_q;
  assign bus.rd_cmd_ready  = rd_cmd_ready;
  assign bus.rd_resp_valid = rd_resp_valid;
  assign bus.rd_resp_data  = rd_resp_data;

  generate
    for (genvar i = 0; i < SEG_COUNT; i++) begin : g_seg
      logic [SEG_DATA_WIDTH-1:0] mem [SEG_DEPTH];
      logic [SEG_DATA_WIDTH-1:0] ram_q;
      logic [SEG_ADDR_WIDTH-1:0] wr_addr;
      logic [SEG_ADDR_WIDTH-1:0] rd_addr;
      logic [SEG_BE_WIDTH-1:0]   wr_be;
      logic [SEG_DATA_WIDTH-1:0] wr_data;

      assign wr_addr = bus.wr_cmd_addr[i*SEG_ADDR_WIDTH +: SEG_ADDR_WIDTH];
      assign rd_addr = bus.rd_cmd_addr[i*SEG_ADDR_WIDTH +: SEG_ADDR_WIDTH];
      assign wr_be   = bus.wr_cmd_be[i*SEG_BE_WIDTH +: SEG_BE_WIDTH];
      assign wr_data = bus.wr_cmd_data[i*SEG_DATA_WIDTH +: SEG_DATA_WIDTH];

      // Read and write share one process so a same-address collision reads old data.
      always_ff @(posedge clk) begin
        if (wr_en[i]) begin
          for (int b = 0; b < SEG_BE_WIDTH; b++) begin
            if (wr_be[b]) mem[wr_addr][b*BYTE_W +: BYTE_W] <= wr_data[b*BYTE_W +: BYTE_W];
          end
        end
        if (rd_en[i]) ram_q <= mem[rd_addr];
      end

      dma_seg_ram_rd_pipe #(
        .PIPELINE       (PIPELINE),
        .SEG_DATA_WIDTH (SEG_DATA_WIDTH)
      ) u_rd_pipe (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (bus.rd_cmd_valid[i]),
        .cmd_ready   (rd_cmd_ready[i]),
        .ram_rd_en   (rd_en[i]),
        .ram_rd_data (ram_q),
        .resp_data   (rd_resp_data[i*SEG_DATA_WIDTH +: SEG_DATA_WIDTH]),
        .resp_valid  (rd_resp_valid[i]),
        .resp_ready  (bus.rd_resp_ready[i])
      );
    end
  endgenerate
endmodule

// File: tb/tb_dma_seg_ram_sdp.sv
// tb/tb_dma_seg_ram_sdp.sv - randomized self-checking bench against a byte-level memory model
module tb_dma_seg_ram_sdp;
  localparam int SEGS  = 2;
  localparam int DW    = 64;
  localparam int BE    = 8;
  localparam int AW    = 10;
  localparam int DEPTH = 1024;
  localparam int NADDR = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dma_seg_ram_sdp_if #(.SIZE(16384), .SEG_COUNT(SEGS), .SEG_DATA_WIDTH(DW),
                       .SEG_BE_WIDTH(BE), .SEG_ADDR_WIDTH(AW)) bus ();

  dma_seg_ram_sdp #(.SIZE(16384), .SEG_COUNT(SEGS), .SEG_DATA_WIDTH(DW),
                    .SEG_BE_WIDTH(BE), .SEG_ADDR_WIDTH(AW), .PIPELINE(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [63:0] ref_mem [SEGS][DEPTH];
  logic [63:0] exp_q [SEGS][$];
  int          resp_cyc [SEGS][$];
  int          acc_cyc [SEGS][$];
  int          resp_cnt [SEGS];
  int          acc_cnt [SEGS];
  logic [63:0] last_resp [SEGS];
  logic [SEGS-1:0] prev_wr_acc = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard: reads see memory before the same-cycle write lands.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      check_eq("rst_wr_cmd_ready", 64'(bus.wr_cmd_ready), 64'd0);
      check_eq("rst_rd_cmd_ready", 64'(bus.rd_cmd_ready), 64'd0);
      for (int s = 0; s < SEGS; s++) exp_q[s].delete();
      prev_wr_acc = '0;
    end else begin
      for (int s = 0; s < SEGS; s++) begin
        check_eq("wr_done", 64'(bus.wr_done[s]), 64'(prev_wr_acc[s]));
        if (bus.rd_resp_valid[s] && bus.rd_resp_ready[s]) begin
          if (exp_q[s].size() == 0) begin
            check_eq("resp_unexpected", 64'(bus.rd_resp_valid[s]), 64'd0);
          end else begin
            check_eq("resp_data", bus.rd_resp_data[s*DW +: DW], exp_q[s].pop_front());
          end
          last_resp[s] = bus.rd_resp_data[s*DW +: DW];
          resp_cnt[s]++;
          resp_cyc[s].push_back(cyc);
        end
        if (bus.rd_cmd_valid[s] && bus.rd_cmd_ready[s]) begin
          exp_q[s].push_back(ref_mem[s][bus.rd_cmd_addr[s*AW +: AW]]);
          acc_cnt[s]++;
          acc_cyc[s].push_back(cyc);
        end
        prev_wr_acc[s] = bus.wr_cmd_valid[s] && bus.wr_cmd_ready[s];
        if (prev_wr_acc[s]) begin
          for (int b = 0; b < BE; b++) begin
            if (bus.wr_cmd_be[s*BE + b])
              ref_mem[s][bus.wr_cmd_addr[s*AW +: AW]][b*8 +: 8] = bus.wr_cmd_data[s*DW + b*8 +: 8];
          end
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    bus.wr_cmd_valid  = '0;
    bus.rd_cmd_valid  = '0;
    bus.rd_resp_ready = '1;
  endtask

  task automatic set_wr(input int s, input int a, input logic [63:0] d, input logic [7:0] be);
    bus.wr_cmd_valid[s]         = 1'b1;
    bus.wr_cmd_addr[s*AW +: AW] = AW'(a);
    bus.wr_cmd_data[s*DW +: DW] = d;
    bus.wr_cmd_be[s*BE +: BE]   = be;
  endtask

  task automatic set_rd(input int s, input int a);
    bus.rd_cmd_valid[s]         = 1'b1;
    bus.rd_cmd_addr[s*AW +: AW] = AW'(a);
  endtask

  task automatic wr(input int s, input int a, input logic [63:0] d, input logic [7:0] be);
    set_wr(s, a, d, be);
    step();
    bus.wr_cmd_valid[s] = 1'b0;
    check_eq("wr_done_next_cycle", 64'(bus.wr_done[s]), 64'd1);
  endtask

  task automatic wait_resp(input int s, input int target);
    int budget = 40;
    while (resp_cnt[s] < target && budget > 0) begin
      step();
      budget--;
    end
    if (resp_cnt[s] < target) check_eq("resp_timeout", 64'(resp_cnt[s]), 64'(target));
  endtask

  task automatic rd_one(input int s, input int a, output logic [63:0] d);
    int target = resp_cnt[s] + 1;
    bus.rd_resp_ready[s] = 1'b1;
    set_rd(s, a);
    step();
    bus.rd_cmd_valid[s] = 1'b0;
    wait_resp(s, target);
    d = last_resp[s];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [63:0] d;
    int a0, r0, r1, ab, rb;
    for (int s = 0; s < SEGS; s++) begin
      resp_cnt[s] = 0;
      acc_cnt[s]  = 0;
    end
    bus.wr_cmd_be   = '0;
    bus.wr_cmd_addr = '0;
    bus.wr_cmd_data = '0;
    bus.rd_cmd_addr = '0;
    idle();
    rst = 1'b1;
    step(3);
    check_eq("rst_resp_valid", 64'(bus.rd_resp_valid), 64'd0);
    check_eq("rst_wr_done", 64'(bus.wr_done), 64'd0);
    rst = 1'b0;
    #1;
    check_eq("wr_cmd_ready_out_of_rst", 64'(bus.wr_cmd_ready), 64'h3);

    for (int a = 0; a < NADDR; a++) begin
      for (int s = 0; s < SEGS; s++) set_wr(s, a, {$urandom, $urandom}, 8'hFF);
      step();
    end
    idle();
    step();

    // Byte-enable merge, read accepted right after the second write
    wr(0, 5, 64'h1122334455667788, 8'hFF);
    wr(0, 5, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
    rd_one(0, 5, d);
    check_eq("be_merge", d, 64'h11223344AAAAAAAA);
    check_eq("wr_done_single", 64'(bus.wr_done[0]), 64'd0);

    // Latency and throughput: 8 back-to-back reads
    ab = acc_cyc[0].size();
    rb = resp_cyc[0].size();
    for (int i = 0; i < 8; i++) begin
      set_rd(0, i);
      step();
    end
    idle();
    step(5);
    check_eq("stream_accepts", 64'(acc_cyc[0].size() - ab), 64'd8);
    check_eq("stream_resps", 64'(resp_cyc[0].size() - rb), 64'd8);
    for (int i = 0; i < 8; i++)
      check_eq("stream_latency", 64'(resp_cyc[0][rb+i]), 64'(acc_cyc[0][ab] + 2 + i));

    // Stall with continuous requests
    a0 = acc_cnt[0];
    r0 = resp_cnt[0];
    bus.rd_resp_ready[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_rd(0, $urandom_range(NADDR - 1));
      step();
    end
    check_eq("stall_accepts", 64'(acc_cnt[0] - a0), 64'd2);
    #1;
    check_eq("stall_cmd_ready", 64'(bus.rd_cmd_ready[0]), 64'd0);
    bus.rd_resp_ready[0] = 1'b1;
    bus.rd_cmd_valid[0]  = 1'b0;
    #1;
    check_eq("release_cmd_ready", 64'(bus.rd_cmd_ready[0]), 64'd1);
    step(4);
    check_eq("stall_resps", 64'(resp_cnt[0] - r0), 64'd2);

    // Read-first collision
    wr(0, 3, 64'hA, 8'hFF);
    r0 = resp_cnt[0];
    set_rd(0, 3);
    set_wr(0, 3, 64'hB, 8'hFF);
    step();
    idle();
    wait_resp(0, r0 + 1);
    check_eq("collision_old", last_resp[0], 64'hA);
    rd_one(0, 3, d);
    check_eq("collision_new", d, 64'hB);

    // Segment independence: seg1 stalled, seg0 streams 16
    r1 = resp_cnt[1];
    a0 = acc_cnt[1];
    bus.rd_resp_ready[1] = 1'b0;
    set_rd(1, 7);
    step();
    set_rd(1, 9);
    ab = acc_cyc[0].size();
    rb = resp_cyc[0].size();
    for (int i = 0; i < 16; i++) begin
      set_rd(0, (i * 3) % NADDR);
      step();
    end
    bus.rd_cmd_valid[0] = 1'b0;
    step(4);
    check_eq("indep_seg1_accepts", 64'(acc_cnt[1] - a0), 64'd2);
    check_eq("indep_seg1_quiet", 64'(resp_cnt[1] - r1), 64'd0);
    check_eq("indep_seg0_resps", 64'(resp_cyc[0].size() - rb), 64'd16);
    for (int i = 0; i < 16; i++)
      check_eq("indep_seg0_latency", 64'(resp_cyc[0][rb+i]), 64'(acc_cyc[0][ab] + 2 + i));
    idle();
    step(4);
    check_eq("indep_seg1_resps", 64'(resp_cnt[1] - r1), 64'd2);

    // Randomized traffic on both segments
    for (int n = 0; n < 400; n++) begin
      for (int s = 0; s < SEGS; s++) begin
        bus.wr_cmd_valid[s]         = ($urandom_range(99) < 50);
        bus.wr_cmd_addr[s*AW +: AW] = AW'($urandom_range(NADDR - 1));
        bus.wr_cmd_data[s*DW +: DW] = {$urandom, $urandom};
        bus.wr_cmd_be[s*BE +: BE]   = 8'($urandom);
        bus.rd_cmd_valid[s]         = ($urandom_range(99) < 60);
        bus.rd_cmd_addr[s*AW +: AW] = AW'($urandom_range(NADDR - 1));
        bus.rd_resp_ready[s]        = ($urandom_range(99) < 70);
      end
      step();
    end
    idle();
    step(10);

    // Reset with two reads in flight
    bus.rd_resp_ready[0] = 1'b0;
    set_rd(0, 5);
    step();
    set_rd(0, 6);
    step();
    idle();
    bus.rd_resp_ready[0] = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.rd_resp_ready = '1;
    for (int i = 0; i < 8; i++) begin
      step();
      check_eq("post_rst_no_resp", 64'(bus.rd_resp_valid), 64'd0);
    end
    rd_one(0, 5, d);
    check_eq("post_rst_seg0", d, ref_mem[0][5]);
    rd_one(1, 7, d);
    check_eq("post_rst_seg1", d, ref_mem[1][7]);

    step(4);
    for (int s = 0; s < SEGS; s++) check_eq("drained", 64'(exp_q[s].size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
